// File: rtl/imem_loader_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot/load controller:
// default memory geometry and the controller state encoding.
package imem_loader_ctrl_pkg;

    localparam int unsigned MEM_DEPTH_DEF = 1024;
    localparam int unsigned ADDR_W_DEF    = 10;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PCRST = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host load stream, instruction-memory write port and CPU control/status
// bundle. The controller uses the slave modport, the host side the master.
interface imem_loader_if
    import imem_loader_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              load_start;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_stall;
    logic              cpu_pc_reset;
    logic [ADDR_W:0]   load_count;
    logic              load_done;
    logic              load_error;

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        output load_ready, mem_we, mem_waddr, mem_wdata,
               cpu_stall, cpu_pc_reset, load_count, load_done, load_error
    );

    modport master (
        output load_start, load_valid, load_data, load_last,
        input  load_ready, mem_we, mem_waddr, mem_wdata,
               cpu_stall, cpu_pc_reset, load_count, load_done, load_error
    );

endinterface

// File: rtl/imem_loader_ctrl.sv
// Boot/load controller: zero-fills instruction memory, streams a program in,
// pulses the CPU PC reset and releases the stall.
module imem_loader_ctrl
    import imem_loader_ctrl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(MEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              load_error_q, load_error_d;

    logic load_ready;
    logic handshake;

    assign handshake = bus.load_valid && load_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_idx_q == CLR_LAST) state_d = ST_WAIT;
            ST_WAIT:  if (bus.load_start) state_d = ST_LOAD;
            // Leave on the last word, or on the word that fills memory.
            ST_LOAD:  if (handshake && (bus.load_last || load_count_q == CNT_LAST))
                          state_d = ST_PCRST;
            ST_PCRST: state_d = ST_RUN;
            ST_RUN:   if (bus.load_start) state_d = ST_LOAD;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        load_ready       = (state_q == ST_LOAD);
        bus.load_ready   = load_ready;
        bus.cpu_stall    = (state_q != ST_RUN);
        bus.cpu_pc_reset = (state_q == ST_PCRST);
        bus.load_done    = (state_q == ST_RUN);
    end

    always_comb begin
        clr_idx_d    = clr_idx_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        load_count_d = load_count_q;
        load_error_d = load_error_q;
        case (state_q)
            ST_CLEAR: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = clr_idx_q;
                mem_wdata_d = '0;
                clr_idx_d   = clr_idx_q + ADDR_W'(1);
            end
            ST_WAIT, ST_RUN: begin
                if (bus.load_start) begin
                    load_count_d = '0;
                    load_error_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    mem_we_d     = 1'b1;
                    mem_waddr_d  = load_count_q[ADDR_W-1:0];
                    mem_wdata_d  = bus.load_data;
                    load_count_d = load_count_q + (ADDR_W+1)'(1);
                    if (!bus.load_last && load_count_q == CNT_LAST) load_error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_idx_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            load_count_q <= '0;
            load_error_q <= 1'b0;
        end else begin
            clr_idx_q    <= clr_idx_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            load_count_q <= load_count_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_waddr  = mem_waddr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.load_count = load_count_q;
    assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl with a behavioural instruction memory
// that commits the registered write port on each rising edge.
module tb_imem_loader_ctrl;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader_ctrl #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] data, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_we",      32'(bus.mem_we), 32'd0);
        check("rst_waddr",   32'(bus.mem_waddr), 32'd0);
        check("rst_wdata",   bus.mem_wdata, 32'd0);
        check("rst_stall",   32'(bus.cpu_stall), 32'd1);
        check("rst_pcrst",   32'(bus.cpu_pc_reset), 32'd0);
        check("rst_ready",   32'(bus.load_ready), 32'd0);
        check("rst_count",   32'(bus.load_count), 32'd0);
        check("rst_done",    32'(bus.load_done), 32'd0);
        check("rst_error",   32'(bus.load_error), 32'd0);
    endtask

    task automatic run_clear();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check("clr_we",    32'(bus.mem_we), 32'd1);
            check("clr_waddr", 32'(bus.mem_waddr), 32'(i));
            check("clr_wdata", bus.mem_wdata, 32'd0);
            check("clr_stall", 32'(bus.cpu_stall), 32'd1);
        end
        step();
        check("clr_we_end", 32'(bus.mem_we), 32'd0);
        check("wait_ready", 32'(bus.load_ready), 32'd0);
        check("wait_stall", 32'(bus.cpu_stall), 32'd1);
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("ld_ready", 32'(bus.load_ready), 32'd1);
        check("ld_count0", 32'(bus.load_count), 32'd0);
        check("ld_stall", 32'(bus.cpu_stall), 32'd1);
        check("ld_done", 32'(bus.load_done), 32'd0);
    endtask

    initial begin
        int bad;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;

        // Power-on reset and full clear
        #1 reset_n = 1'b0;
        #2 check_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_clear();

        // Three-word program, back-to-back
        start_load();
        send(32'h0050_0093, 1'b0);
        check("p3_we0", 32'(bus.mem_we), 32'd1);
        check("p3_addr0", 32'(bus.mem_waddr), 32'd0);
        check("p3_data0", bus.mem_wdata, 32'h0050_0093);
        check("p3_count1", 32'(bus.load_count), 32'd1);
        send(32'h0010_0113, 1'b0);
        check("p3_addr1", 32'(bus.mem_waddr), 32'd1);
        send(32'h0020_81B3, 1'b1);
        check("p3_we2", 32'(bus.mem_we), 32'd1);
        check("p3_addr2", 32'(bus.mem_waddr), 32'd2);
        check("p3_pcrst", 32'(bus.cpu_pc_reset), 32'd1);
        check("p3_ready_off", 32'(bus.load_ready), 32'd0);
        check("p3_stall_pcrst", 32'(bus.cpu_stall), 32'd1);
        check("p3_count3", 32'(bus.load_count), 32'd3);
        step();
        check("p3_pcrst_off", 32'(bus.cpu_pc_reset), 32'd0);
        check("p3_stall_off", 32'(bus.cpu_stall), 32'd0);
        check("p3_done", 32'(bus.load_done), 32'd1);
        check("p3_we_off", 32'(bus.mem_we), 32'd0);
        check("p3_mem0", mem[0], 32'h0050_0093);
        check("p3_mem1", mem[1], 32'h0010_0113);
        check("p3_mem2", mem[2], 32'h0020_81B3);
        check("p3_mem3", mem[3], 32'h0000_0000);

        // Reload from RUN with load_valid toggling every cycle
        start_load();
        for (int k = 0; k < 3; k++) begin
            send(32'h1111_0000 + 32'(k), k == 2);
            check("tg_we", 32'(bus.mem_we), 32'd1);
            check("tg_addr", 32'(bus.mem_waddr), 32'(k));
            check("tg_data", bus.mem_wdata, 32'h1111_0000 + 32'(k));
            if (k < 2) begin
                step();
                check("tg_idle_we", 32'(bus.mem_we), 32'd0);
                check("tg_count", 32'(bus.load_count), 32'(k + 1));
            end
        end
        check("tg_pcrst", 32'(bus.cpu_pc_reset), 32'd1);
        step();
        check("tg_done", 32'(bus.load_done), 32'd1);
        check("tg_mem0", mem[0], 32'h1111_0000);
        check("tg_mem1", mem[1], 32'h1111_0001);
        check("tg_mem2", mem[2], 32'h1111_0002);

        // Overflow: 1024 words with no load_last, then a 1025th offered
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            send(32'hA5A5_0000 ^ 32'(i), 1'b0);
            check("ov_we", 32'(bus.mem_we), 32'd1);
            check("ov_addr", 32'(bus.mem_waddr), 32'(i));
        end
        check("ov_error", 32'(bus.load_error), 32'd1);
        check("ov_count", 32'(bus.load_count), 32'd1024);
        check("ov_ready_off", 32'(bus.load_ready), 32'd0);
        check("ov_pcrst", 32'(bus.cpu_pc_reset), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hFFFF_FFFF;
        step();
        bus.load_valid = 1'b0;
        check("ov_no_write", 32'(bus.mem_we), 32'd0);
        check("ov_done", 32'(bus.load_done), 32'd1);
        check("ov_error_run", 32'(bus.load_error), 32'd1);
        check("ov_count_hold", 32'(bus.load_count), 32'd1024);
        step();
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== (32'hA5A5_0000 ^ 32'(i))) bad++;
        check("ov_mem_bad", 32'(bad), 32'd0);

        // Two-word reload from RUN clears the error, keeps word 2
        start_load();
        check("rl_error_clr", 32'(bus.load_error), 32'd0);
        send(32'hCAFE_F00D, 1'b0);
        send(32'h1234_5678, 1'b1);
        check("rl_pcrst", 32'(bus.cpu_pc_reset), 32'd1);
        check("rl_stall", 32'(bus.cpu_stall), 32'd1);
        check("rl_count", 32'(bus.load_count), 32'd2);
        step();
        check("rl_stall_off", 32'(bus.cpu_stall), 32'd0);
        check("rl_pcrst_off", 32'(bus.cpu_pc_reset), 32'd0);
        check("rl_mem0", mem[0], 32'hCAFE_F00D);
        check("rl_mem1", mem[1], 32'h1234_5678);
        check("rl_mem2", mem[2], 32'hA5A5_0002);
        check("rl_error", 32'(bus.load_error), 32'd0);

        // Asynchronous reset after 5 words of a load, then re-clear
        start_load();
        for (int k = 0; k < 5; k++) send(32'h7700_0000 + 32'(k), 1'b0);
        check("ar_count5", 32'(bus.load_count), 32'd5);
        #2 reset_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        run_clear();
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'd0) bad++;
        check("ar_mem_nonzero", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
